// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game's bullet slot logic.
package tank_pkg;

    localparam int DEF_NUM_SLOTS = 3;
    localparam int LIFE_W        = 9;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LAUNCH = 2'd1,
        FLYING = 2'd2
    } slot_state_t;

    typedef logic owner_t;
    localparam owner_t OWNER_T1 = 1'b0;
    localparam owner_t OWNER_T2 = 1'b1;

    // A fresh fire edge outranks the per-frame clear; a destroyed tank never holds a request.
    function automatic logic next_pend(input logic pend, input logic rise, input logic won,
                                       input logic tick, input logic shot);
        if (shot)
            return 1'b0;
        else if (rise)
            return 1'b1;
        else if (won || tick)
            return 1'b0;
        else
            return pend;
    endfunction

endpackage

// File: rtl/bullet_slot_fsm.sv
// One bullet slot: FREE -> LAUNCH -> FLYING -> FREE, with owner and a per-frame life counter.
module bullet_slot_fsm
    import tank_pkg::*;
#(
    parameter int LIFE_FRAMES = 300
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   round_reset,
    input  logic   grant,
    input  owner_t grant_owner,
    input  logic   hit,
    input  logic   frame_tick,
    output logic   active,
    output logic   launch,
    output logic   free,
    output owner_t owner
);

    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIFE_FRAMES);
    localparam logic [LIFE_W-1:0] LIFE_ONE  = LIFE_W'(1);

    slot_state_t       state, state_next;
    logic [LIFE_W-1:0] life, life_next;
    owner_t            owner_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FREE;
            life  <= '0;
            owner <= OWNER_T1;
        end else begin
            state <= state_next;
            life  <= life_next;
            owner <= owner_next;
        end
    end

    // Life only counts down while flying; the launch cycle is never cut short by a frame tick.
    always_comb begin
        state_next = state;
        life_next  = life;
        owner_next = owner;
        if (round_reset) begin
            state_next = FREE;
            life_next  = '0;
            owner_next = OWNER_T1;
        end else begin
            case (state)
                FREE: begin
                    if (grant) begin
                        state_next = LAUNCH;
                        life_next  = LIFE_INIT;
                        owner_next = grant_owner;
                    end
                end
                LAUNCH: state_next = hit ? FREE : FLYING;
                FLYING: begin
                    if (hit) begin
                        state_next = FREE;
                    end else if (frame_tick) begin
                        life_next = life - LIFE_ONE;
                        if (life == LIFE_ONE)
                            state_next = FREE;
                    end
                end
                default: state_next = FREE;
            endcase
        end
    end

    assign active = (state == LAUNCH) || (state == FLYING);
    assign launch = (state == LAUNCH);
    assign free   = (state == FREE);

endmodule

// File: rtl/bullet_slot_arbiter.sv
// Shares the bullet slots between two tanks: fire edge detect, round-robin grant, cooldowns.
module bullet_slot_arbiter
    import tank_pkg::*;
#(
    parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
    parameter int LIFE_FRAMES     = 300,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int MAX_PER_TANK    = 2
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic                 frame_tick,
    input  logic                 round_reset,
    input  logic                 fire1,
    input  logic                 fire2,
    input  logic                 tank1_shot,
    input  logic                 tank2_shot,
    input  logic [NUM_SLOTS-1:0] hit,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic [NUM_SLOTS-1:0] launch,
    output logic                 grant1,
    output logic                 grant2
);

    localparam int                COOL_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(COOLDOWN_FRAMES);
    localparam logic [COOL_W-1:0] COOL_ONE  = COOL_W'(1);
    localparam logic [1:0]        MAX_OWN   = 2'(MAX_PER_TANK);

    if (LIFE_FRAMES > (1 << LIFE_W) - 1 || LIFE_FRAMES < 1) begin : g_life_check
        $error("LIFE_FRAMES must be in 1..511");
    end

    logic              fire1_q, fire2_q, pend1, pend2, rr_ptr;
    logic [COOL_W-1:0] cool1, cool2;
    logic [1:0]        owned1, owned2;
    logic [NUM_SLOTS-1:0] slot_free, pick, slot_grant;
    logic              found, any_free, elig1, elig2, win1, win2;
    owner_t            grant_owner;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        bullet_slot_fsm #(.LIFE_FRAMES(LIFE_FRAMES)) u_slot (
            .clk        (CLK),
            .rst_n      (Reset_n),
            .round_reset(round_reset),
            .grant      (slot_grant[i]),
            .grant_owner(grant_owner),
            .hit        (hit[i]),
            .frame_tick (frame_tick),
            .active     (slot_active[i]),
            .launch     (launch[i]),
            .free       (slot_free[i]),
            .owner      (slot_owner[i])
        );
    end

    // Ownership and the free-slot pick use registered slot state, so a slot released this
    // cycle cannot be handed out until the next one.
    always_comb begin
        owned1 = '0;
        owned2 = '0;
        pick   = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_active[i]) begin
                if (slot_owner[i] == OWNER_T2)
                    owned2 = owned2 + 2'd1;
                else
                    owned1 = owned1 + 2'd1;
            end
            if (slot_free[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign any_free    = |slot_free;
    assign elig1       = pend1 && !tank1_shot && (cool1 == '0) && (owned1 < MAX_OWN) && any_free;
    assign elig2       = pend2 && !tank2_shot && (cool2 == '0) && (owned2 < MAX_OWN) && any_free;
    assign win1        = elig1 && (!elig2 || !rr_ptr);
    assign win2        = elig2 && (!elig1 || rr_ptr);
    assign grant_owner = win2 ? OWNER_T2 : OWNER_T1;
    assign slot_grant  = (win1 || win2) ? pick : '0;

    // rr_ptr only moves when both tanks actually contended for the grant.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            fire1_q <= 1'b0;
            fire2_q <= 1'b0;
            pend1   <= 1'b0;
            pend2   <= 1'b0;
            cool1   <= '0;
            cool2   <= '0;
            rr_ptr  <= 1'b0;
            grant1  <= 1'b0;
            grant2  <= 1'b0;
        end else if (round_reset) begin
            fire1_q <= 1'b0;
            fire2_q <= 1'b0;
            pend1   <= 1'b0;
            pend2   <= 1'b0;
            cool1   <= '0;
            cool2   <= '0;
            rr_ptr  <= 1'b0;
            grant1  <= 1'b0;
            grant2  <= 1'b0;
        end else begin
            fire1_q <= fire1;
            fire2_q <= fire2;
            pend1   <= next_pend(pend1, fire1 && !fire1_q, win1, frame_tick, tank1_shot);
            pend2   <= next_pend(pend2, fire2 && !fire2_q, win2, frame_tick, tank2_shot);
            if (win1)
                cool1 <= COOL_INIT;
            else if (frame_tick && cool1 != '0)
                cool1 <= cool1 - COOL_ONE;
            if (win2)
                cool2 <= COOL_INIT;
            else if (frame_tick && cool2 != '0)
                cool2 <= cool2 - COOL_ONE;
            if (elig1 && elig2)
                rr_ptr <= !rr_ptr;
            grant1 <= win1;
            grant2 <= win2;
        end
    end

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Directed bench for bullet_slot_arbiter; expected outputs are queued per step and popped after each edge.
module tb_bullet_slot_arbiter;

    localparam int N = 3;

    logic         CLK = 1'b0;
    logic         Reset_n = 1'b0;
    logic         frame_tick = 1'b0;
    logic         round_reset = 1'b0;
    logic         fire1 = 1'b0;
    logic         fire2 = 1'b0;
    logic         tank1_shot = 1'b0;
    logic         tank2_shot = 1'b0;
    logic [N-1:0] hit = '0;
    logic [N-1:0] slot_active, slot_owner, launch;
    logic         grant1, grant2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [10:0] value;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    bullet_slot_arbiter #(
        .NUM_SLOTS(N), .LIFE_FRAMES(300), .COOLDOWN_FRAMES(15), .MAX_PER_TANK(2)
    ) dut (
        .CLK(CLK), .Reset_n(Reset_n), .frame_tick(frame_tick), .round_reset(round_reset),
        .fire1(fire1), .fire2(fire2), .tank1_shot(tank1_shot), .tank2_shot(tank2_shot),
        .hit(hit), .slot_active(slot_active), .slot_owner(slot_owner), .launch(launch),
        .grant1(grant1), .grant2(grant2)
    );

    task automatic apply_stimulus(input logic f1, input logic f2, input logic ft,
                                  input logic rr, input logic [N-1:0] h);
        fire1       = f1;
        fire2       = f2;
        frame_tick  = ft;
        round_reset = rr;
        hit         = h;
    endtask

    task automatic expect_out(input string tag, input logic g1, input logic g2,
                              input logic [2:0] l, input logic [2:0] a, input logic [2:0] o);
        exp_t e;
        e.tag   = tag;
        e.value = {g1, g2, l, a, o};
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t        e;
        logic [10:0] obs;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: observed no queued entry, required one");
        end else begin
            e   = sb.pop_front();
            obs = {grant1, grant2, launch, slot_active, slot_owner};
            assert (obs === e.value) else begin
                errors++;
                $error("[TB] FAIL %s: observed g1/g2/launch/active/owner=%b/%b/%b/%b/%b required %b/%b/%b/%b/%b",
                       e.tag, obs[10], obs[9], obs[8:6], obs[5:3], obs[2:0],
                       e.value[10], e.value[9], e.value[8:6], e.value[5:3], e.value[2:0]);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic g1, input logic g2,
                       input logic [2:0] l, input logic [2:0] a, input logic [2:0] o);
        expect_out(tag, g1, g2, l, a, o);
        @(posedge CLK);
        #1;
        check_output();
    endtask

    task automatic frames(input string tag, input int n, input logic [2:0] a, input logic [2:0] o);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc(tag, 1'b0, 1'b0, 3'b000, a, o);
            frame_tick = 1'b0;
            cyc(tag, 1'b0, 1'b0, 3'b000, a, o);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_stimulus(0, 0, 0, 0, '0);
        repeat (2) @(posedge CLK);
        #1;
        expect_out("reset_state", 0, 0, 3'b000, 3'b000, 3'b000);
        check_output();
        Reset_n = 1'b1;
        cyc("idle", 0, 0, 3'b000, 3'b000, 3'b000);

        // Single uncontended shot; a held key must not re-request even once cooldown is over.
        fire1 = 1'b1;
        cyc("a_pend",  0, 0, 3'b000, 3'b000, 3'b000);
        cyc("a_grant", 1, 0, 3'b001, 3'b001, 3'b000);
        cyc("a_fly",   0, 0, 3'b000, 3'b001, 3'b000);
        for (int i = 0; i < 100; i++) begin
            frame_tick = (i % 4 == 0);
            cyc("a_hold", 0, 0, 3'b000, 3'b001, 3'b000);
        end
        apply_stimulus(0, 0, 0, 0, '0);
        cyc("a_release", 0, 0, 3'b000, 3'b001, 3'b000);
        round_reset = 1'b1;
        cyc("rr_clear1", 0, 0, 3'b000, 3'b000, 3'b000);
        round_reset = 1'b0;

        // Simultaneous fire: tank1 first, then rr favours tank2 on the repeat.
        apply_stimulus(1, 1, 0, 0, '0);
        cyc("b_pend", 0, 0, 3'b000, 3'b000, 3'b000);
        cyc("b_t1",   1, 0, 3'b001, 3'b001, 3'b000);
        cyc("b_t2",   0, 1, 3'b010, 3'b011, 3'b010);
        cyc("b_idle", 0, 0, 3'b000, 3'b011, 3'b010);
        apply_stimulus(0, 0, 0, 0, '0);
        frames("b_cool", 16, 3'b011, 3'b010);
        apply_stimulus(1, 1, 0, 0, '0);
        cyc("b2_pend",    0, 0, 3'b000, 3'b011, 3'b010);
        cyc("b2_t2_wins", 0, 1, 3'b100, 3'b111, 3'b110);
        cyc("b2_t1_full", 0, 0, 3'b000, 3'b111, 3'b110);
        apply_stimulus(0, 0, 0, 0, '0);
        frames("b2_tick", 1, 3'b111, 3'b110);

        // Per-tank limit: third request is dropped and does not survive a frame tick.
        round_reset = 1'b1;
        cyc("rr_clear2", 0, 0, 3'b000, 3'b000, 3'b000);
        round_reset = 1'b0;
        fire1 = 1'b1;
        cyc("c1_pend",  0, 0, 3'b000, 3'b000, 3'b000);
        cyc("c1_grant", 1, 0, 3'b001, 3'b001, 3'b000);
        fire1 = 1'b0;
        frames("c1_cool", 16, 3'b001, 3'b000);
        fire1 = 1'b1;
        cyc("c2_pend",  0, 0, 3'b000, 3'b001, 3'b000);
        cyc("c2_grant", 1, 0, 3'b010, 3'b011, 3'b000);
        fire1 = 1'b0;
        frames("c2_cool", 16, 3'b011, 3'b000);
        fire1 = 1'b1;
        cyc("c3_pend", 0, 0, 3'b000, 3'b011, 3'b000);
        cyc("c3_drop", 0, 0, 3'b000, 3'b011, 3'b000);
        fire1 = 1'b0;
        cyc("c3_wait", 0, 0, 3'b000, 3'b011, 3'b000);
        frame_tick = 1'b1;
        cyc("c3_tick", 0, 0, 3'b000, 3'b011, 3'b000);
        apply_stimulus(0, 0, 0, 0, 3'b001);
        cyc("c3_hit", 0, 0, 3'b000, 3'b010, 3'b000);
        hit = '0;
        cyc("c3_nogrant_a", 0, 0, 3'b000, 3'b010, 3'b000);
        cyc("c3_nogrant_b", 0, 0, 3'b000, 3'b010, 3'b000);

        // Hit during launch, then full lifetime expiry of slot 0.
        round_reset = 1'b1;
        cyc("rr_clear3", 0, 0, 3'b000, 3'b000, 3'b000);
        apply_stimulus(1, 1, 0, 0, '0);
        cyc("d_pend", 0, 0, 3'b000, 3'b000, 3'b000);
        cyc("d_t1",   1, 0, 3'b001, 3'b001, 3'b000);
        cyc("d_t2",   0, 1, 3'b010, 3'b011, 3'b010);
        apply_stimulus(0, 0, 0, 0, 3'b010);
        cyc("d_hit1", 0, 0, 3'b000, 3'b001, 3'b010);
        hit = '0;
        frames("d_life", 299, 3'b001, 3'b010);
        frame_tick = 1'b1;
        cyc("d_expire", 0, 0, 3'b000, 3'b000, 3'b010);
        frame_tick = 1'b0;
        cyc("d_after", 0, 0, 3'b000, 3'b000, 3'b010);

        // All slots busy: release and pending fire2 in one cycle, grant follows a cycle later.
        round_reset = 1'b1;
        cyc("rr_clear4", 0, 0, 3'b000, 3'b000, 3'b000);
        apply_stimulus(1, 1, 0, 0, '0);
        cyc("e_pend", 0, 0, 3'b000, 3'b000, 3'b000);
        cyc("e_t1",   1, 0, 3'b001, 3'b001, 3'b000);
        cyc("e_t2",   0, 1, 3'b010, 3'b011, 3'b010);
        apply_stimulus(0, 0, 0, 0, '0);
        frames("e_cool", 16, 3'b011, 3'b010);
        fire1 = 1'b1;
        cyc("e3_pend",  0, 0, 3'b000, 3'b011, 3'b010);
        cyc("e3_grant", 1, 0, 3'b100, 3'b111, 3'b010);
        fire1 = 1'b0;
        fire2 = 1'b1;
        cyc("e4_pend", 0, 0, 3'b000, 3'b111, 3'b010);
        hit = 3'b001;
        cyc("e4_hit_no_grant", 0, 0, 3'b000, 3'b110, 3'b010);
        hit = '0;
        cyc("e4_grant", 0, 1, 3'b001, 3'b111, 3'b011);

        // Asynchronous reset while slot 0 is in LAUNCH.
        #2;
        Reset_n = 1'b0;
        fire2   = 1'b0;
        #1;
        expect_out("f_async_reset", 0, 0, 3'b000, 3'b000, 3'b000);
        check_output();
        @(posedge CLK);
        #1;
        Reset_n = 1'b1;
        cyc("f_idle", 0, 0, 3'b000, 3'b000, 3'b000);

        // round_reset overrides fire edges arriving in the same cycle.
        fire1 = 1'b1;
        cyc("g_pend",  0, 0, 3'b000, 3'b000, 3'b000);
        cyc("g_grant", 1, 0, 3'b001, 3'b001, 3'b000);
        fire1 = 1'b0;
        cyc("g_rel", 0, 0, 3'b000, 3'b001, 3'b000);
        apply_stimulus(1, 1, 0, 1, '0);
        cyc("g_rr", 0, 0, 3'b000, 3'b000, 3'b000);
        apply_stimulus(0, 0, 0, 0, '0);
        cyc("g_quiet1", 0, 0, 3'b000, 3'b000, 3'b000);
        cyc("g_quiet2", 0, 0, 3'b000, 3'b000, 3'b000);

        // A destroyed tank cannot request.
        tank2_shot = 1'b1;
        fire2      = 1'b1;
        cyc("h_shot_a", 0, 0, 3'b000, 3'b000, 3'b000);
        cyc("h_shot_b", 0, 0, 3'b000, 3'b000, 3'b000);
        cyc("h_shot_c", 0, 0, 3'b000, 3'b000, 3'b000);
        tank2_shot = 1'b0;
        fire2      = 1'b0;
        cyc("h_shot_d", 0, 0, 3'b000, 3'b000, 3'b000);
        cyc("h_shot_e", 0, 0, 3'b000, 3'b000, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
